// File: rtl/uncache_axi_bridge.sv
// Bridges a single-beat uncached request (en/wsel/addr/wdata) onto AXI4 as one read or one
// write transaction, one outstanding at a time, answering with a one-cycle reload pulse.
module uncache_axi_bridge #(
    parameter int                ID_WD = 4,
    parameter logic [ID_WD-1:0]  RD_ID = 4'd1,
    parameter logic [ID_WD-1:0]  WR_ID = 4'd1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             axi_en,
    input  logic [3:0]       axi_wsel,
    input  logic [31:0]      axi_addr,
    input  logic [31:0]      axi_wdata,
    output logic             reload,
    output logic [31:0]      axi_rdata,
    output logic             bus_err,
    output logic [ID_WD-1:0] arid,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    input  logic [ID_WD-1:0] rid,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready,
    output logic [ID_WD-1:0] awid,
    output logic [31:0]      awaddr,
    output logic [7:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             wlast,
    output logic             wvalid,
    input  logic             wready,
    input  logic [ID_WD-1:0] bid,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_RD_ADDR = 6'b000010,
        S_RD_DATA = 6'b000100,
        S_WR_REQ  = 6'b001000,
        S_WR_RESP = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_err;
    logic        w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_err_nxt;
    logic [31:0] r_araddr, r_awaddr, r_wdata, r_rdata;
    logic [31:0] w_araddr_nxt, w_awaddr_nxt, w_wdata_nxt, w_rdata_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        w_aw_left, w_w_left;
    logic        w_unused;

    // Single outstanding transaction, so response ids and rlast carry no information.
    assign w_unused  = &{1'b0, rid, rlast, bid};

    assign w_aw_left = r_awvalid & ~awready;
    assign w_w_left  = r_wvalid  & ~wready;

    always_comb begin
        w_state_nxt   = r_state;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_err_nxt     = r_err;
        w_araddr_nxt  = r_araddr;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_rdata_nxt   = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (axi_en) begin
                    if (axi_wsel == 4'b0000) begin
                        w_araddr_nxt  = axi_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_ADDR;
                    end else begin
                        w_awaddr_nxt  = axi_addr;
                        w_wdata_nxt   = axi_wdata;
                        w_wstrb_nxt   = axi_wsel;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = S_WR_REQ;
                    end
                end
            end
            S_RD_ADDR: begin
                if (r_arvalid && arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid && r_rready) begin
                    w_rdata_nxt  = rdata;
                    w_err_nxt    = (rresp != 2'b00);
                    w_rready_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end
            end
            S_WR_REQ: begin
                // AW and W retire independently; B is only awaited once both have gone.
                w_awvalid_nxt = w_aw_left;
                w_wvalid_nxt  = w_w_left;
                if (!w_aw_left && !w_w_left) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid && r_bready) begin
                    w_err_nxt    = (bresp != 2'b00);
                    w_bready_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt   = S_IDLE;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_err     <= 1'b0;
            r_araddr  <= 32'h0;
            r_awaddr  <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_rdata   <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_err     <= w_err_nxt;
            r_araddr  <= w_araddr_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign reload    = (r_state == S_DONE);
    assign bus_err   = (r_state == S_DONE) & r_err;
    assign axi_rdata = r_rdata;

    assign arid      = RD_ID;
    assign araddr    = r_araddr;
    assign arlen     = 8'd0;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;

    assign awid      = WR_ID;
    assign awaddr    = r_awaddr;
    assign awlen     = 8'd0;
    assign awsize    = 3'b010;
    assign awburst   = 2'b01;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wlast     = 1'b1;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;

endmodule
